// File: rtl/fifo_burst_writer_if.sv
// Write-side bus of the burst writer: request channel, upstream stream, and async FIFO write port.
interface fifo_burst_writer_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
);
  logic                 req_valid;
  logic [ADDR_SIZE:0]   req_len;
  logic                 req_ready;
  logic                 s_valid;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_ready;
  logic                 winc;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wfull;
  logic [ADDR_SIZE:0]   wptr;
  logic [ADDR_SIZE:0]   wq2_rptr;

  // master: the burst writer itself
  modport master (
    input  req_valid, req_len, s_valid, s_data, wfull, wptr, wq2_rptr,
    output req_ready, s_ready, winc, wdata
  );

  modport slave (
    output req_valid, req_len, s_valid, s_data, wfull, wptr, wq2_rptr,
    input  req_ready, s_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// Burst initiator for the async FIFO write side; only starts a burst when it fits in free space.
// Optional almost-full output enabled by FIFO_BURST_WR_ALMOST_FULL_EN.
module fifo_burst_writer #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = (1 << ADDR_SIZE) - 2
`endif
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_burst_writer_if.master bus,
  output logic [ADDR_SIZE:0] wlevel,
  output logic               busy,
  output logic               burst_done,
  output logic               req_err
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
  ,
  output logic               walmost_full
`endif
);

  // state      | meaning
  // IDLE       | waiting for a request
  // WAIT_SPACE | accepted, waiting until free >= remaining
  // BURST      | streaming words into the FIFO
  // SETTLE     | one cycle for wlevel to catch the last write
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, SETTLE} state_t;

  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] ONE   = (ADDR_SIZE+1)'(1);

  state_t             state;
  logic [ADDR_SIZE:0] remaining;
  logic [ADDR_SIZE:0] wlevel_next;
  logic [ADDR_SIZE:0] free;
  logic               req_ready_q;
  logic               wr_fire;

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign wlevel_next = gray2bin(bus.wptr) - gray2bin(bus.wq2_rptr);
  assign free        = DEPTH - wlevel;

  // wfull gating keeps words safe even if the space check is ever defeated
  assign wr_fire       = (state == BURST) && bus.s_valid && !bus.wfull;
  assign bus.winc      = wr_fire;
  assign bus.s_ready   = wr_fire;
  assign bus.wdata     = bus.s_data;
  assign bus.req_ready = req_ready_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      wlevel      <= '0;
      req_ready_q <= 1'b0;
      burst_done  <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      wlevel      <= wlevel_next;
      req_ready_q <= 1'b0;
      burst_done  <= 1'b0;
      req_err     <= 1'b0;
      case (state)
        IDLE: begin
          // req_ready is registered, so a request still held while it is high is not taken twice
          if (bus.req_valid && !req_ready_q) begin
            req_ready_q <= 1'b1;
            if (bus.req_len > DEPTH) begin
              req_err <= 1'b1;
            end else if (bus.req_len == '0) begin
              burst_done <= 1'b1;
            end else begin
              remaining <= bus.req_len;
              state     <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (free >= remaining) state <= BURST;
        end
        BURST: begin
          if (wr_fire) begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state      <= SETTLE;
              burst_done <= 1'b1;
            end
          end
        end
        SETTLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE:0] AF_T = AF_THRESH[ADDR_SIZE:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) walmost_full <= 1'b0;
    else         walmost_full <= (wlevel_next >= AF_T);
  end
`endif

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer with a small FIFO pointer model on the write side.
module tb_fifo_burst_writer;
  logic       wclk;
  logic       wrst_n;
  logic [4:0] wlevel;
  logic       busy;
  logic       burst_done;
  logic       req_err;
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int passed = 0;
  int total  = 0;

  fifo_burst_writer_if #(.ADDR_SIZE(4), .DATA_SIZE(8)) bif ();

  fifo_burst_writer #(.ADDR_SIZE(4), .DATA_SIZE(8)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .bus        (bif),
    .wlevel     (wlevel),
    .busy       (busy),
    .burst_done (burst_done),
    .req_err    (req_err)
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // write pointer model: loadable binary counter advanced by winc
  logic [4:0] wbin, rbin, load_val;
  logic       load;
  always @(posedge wclk) begin
    if (load)          wbin <= load_val;
    else if (bif.winc) wbin <= wbin + 5'd1;
  end
  assign bif.wptr     = wbin ^ (wbin >> 1);
  assign bif.wq2_rptr = rbin ^ (rbin >> 1);

  task automatic cyc(input logic rv, input logic [4:0] rl, input logic sv, input logic [7:0] sd);
    @(negedge wclk);
    bif.req_valid = rv;
    bif.req_len   = rl;
    bif.s_valid   = sv;
    bif.s_data    = sd;
    #1;
  endtask

  task automatic set_ptrs(input logic [4:0] w, input logic [4:0] r);
    @(negedge wclk);
    load = 1'b1; load_val = w; rbin = r;
    @(negedge wclk);
    load = 1'b0;
    @(negedge wclk);
    #1;
  endtask

  // Runs a request (optional) and streams data until one cycle past burst_done or budget expiry.
  task automatic stream(input bit do_req, input logic [4:0] len, input bit toggle,
                        input logic [7:0] base, input int budget,
                        output int nwr, output int first_wr, output int last_wr,
                        output int done_cyc, output int ndone, output int nrdy, output int bad);
    logic [7:0] exp_d;
    nwr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; ndone = 0; nrdy = 0; bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge wclk);
      bif.req_valid = do_req && (c == 0);
      bif.req_len   = len;
      bif.s_valid   = toggle ? (c % 2 == 0) : 1'b1;
      exp_d         = base + 8'(nwr);
      bif.s_data    = exp_d;
      #1;
      if (bif.req_ready) nrdy++;
      if (bif.winc) begin
        if (bif.wdata !== exp_d || bif.s_valid !== 1'b1 || bif.s_ready !== 1'b1) bad++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        nwr++;
      end else if (bif.s_ready !== 1'b0) begin
        bad++;
      end
      if (burst_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 1) break;
    end
    @(negedge wclk);
    bif.req_valid = 1'b0;
    bif.s_valid   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    load = 1'b1; load_val = 5'd0; rbin = 5'd0;
    bif.req_valid = 1'b0; bif.req_len = '0; bif.s_valid = 1'b0; bif.s_data = '0; bif.wfull = 1'b0;
    repeat (3) @(negedge wclk);
    #1;
    total++; if (wlevel !== 5'd0) $display("FAIL reset_wlevel got %0d exp 0", wlevel); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (bif.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b exp 0", bif.req_ready); else passed++;
    total++; if (burst_done !== 1'b0 || req_err !== 1'b0) $display("FAIL reset_pulses got done=%b err=%b exp 0/0", burst_done, req_err); else passed++;
    total++; if (bif.winc !== 1'b0 || bif.s_ready !== 1'b0) $display("FAIL reset_winc got winc=%b s_ready=%b exp 0/0", bif.winc, bif.s_ready); else passed++;
    @(negedge wclk);
    load = 1'b0;
    wrst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic_burst();
    int nwr, fw, lw, dc, nd, nr, bad;
    stream(1'b1, 5'd5, 1'b0, 8'hA0, 40, nwr, fw, lw, dc, nd, nr, bad);
    total++; if (nr !== 1) $display("FAIL basic_req_ready got %0d pulses exp 1", nr); else passed++;
    total++; if (nwr !== 5) $display("FAIL basic_writes got %0d exp 5", nwr); else passed++;
    total++; if (lw - fw !== 4) $display("FAIL basic_consecutive got span %0d exp 4", lw - fw); else passed++;
    total++; if (bad !== 0) $display("FAIL basic_data got %0d bad words exp 0", bad); else passed++;
    total++; if (dc !== lw + 1 || nd !== 1) $display("FAIL basic_done got cyc %0d count %0d exp cyc %0d count 1", dc, nd, lw + 1); else passed++;
    total++; if (wlevel !== 5'd5) $display("FAIL basic_wlevel got %0d exp 5", wlevel); else passed++;
  endtask

  task automatic test_wait_space();
    int nwr, fw, lw, dc, nd, nr, bad, held_wr;
    set_ptrs(5'd12, 5'd0);
    total++; if (wlevel !== 5'd12) $display("FAIL wait_start_level got %0d exp 12", wlevel); else passed++;
    cyc(1'b1, 5'd6, 1'b1, 8'h10);
    held_wr = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 5'd6, 1'b1, 8'h10);
      if (bif.winc) held_wr++;
    end
    total++; if (held_wr !== 0) $display("FAIL wait_no_winc got %0d writes exp 0", held_wr); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL wait_busy got %b exp 1", busy); else passed++;
    rbin = 5'd2;
    stream(1'b0, 5'd6, 1'b0, 8'h10, 40, nwr, fw, lw, dc, nd, nr, bad);
    total++; if (nwr !== 6 || bad !== 0) $display("FAIL wait_burst got %0d writes %0d bad exp 6/0", nwr, bad); else passed++;
    total++; if (dc !== lw + 1) $display("FAIL wait_done got cyc %0d exp %0d", dc, lw + 1); else passed++;
    total++; if (wlevel !== 5'd16) $display("FAIL wait_full_level got %0d exp 16", wlevel); else passed++;
  endtask

  task automatic test_zero_and_err();
    cyc(1'b1, 5'd0, 1'b1, 8'h00);
    cyc(1'b0, 5'd0, 1'b1, 8'h00);
    total++; if (bif.req_ready !== 1'b1 || burst_done !== 1'b1) $display("FAIL zero_len got ready=%b done=%b exp 1/1", bif.req_ready, burst_done); else passed++;
    total++; if (busy !== 1'b0 || bif.winc !== 1'b0) $display("FAIL zero_idle got busy=%b winc=%b exp 0/0", busy, bif.winc); else passed++;
    cyc(1'b1, 5'd17, 1'b1, 8'h00);
    cyc(1'b1, 5'd17, 1'b1, 8'h00);
    total++; if (req_err !== 1'b1 || bif.req_ready !== 1'b1 || burst_done !== 1'b0) $display("FAIL err_pulse got err=%b ready=%b done=%b exp 1/1/0", req_err, bif.req_ready, burst_done); else passed++;
    total++; if (busy !== 1'b0 || bif.winc !== 1'b0) $display("FAIL err_idle got busy=%b winc=%b exp 0/0", busy, bif.winc); else passed++;
    cyc(1'b0, 5'd17, 1'b0, 8'h00);
    total++; if (req_err !== 1'b0 || bif.req_ready !== 1'b0) $display("FAIL err_single got err=%b ready=%b exp 0/0", req_err, bif.req_ready); else passed++;
  endtask

  task automatic test_valid_gaps();
    int nwr, fw, lw, dc, nd, nr, bad;
    set_ptrs(5'd0, 5'd0);
    stream(1'b1, 5'd4, 1'b1, 8'h40, 40, nwr, fw, lw, dc, nd, nr, bad);
    total++; if (nwr !== 4) $display("FAIL gaps_writes got %0d exp 4", nwr); else passed++;
    total++; if (bad !== 0) $display("FAIL gaps_data got %0d bad exp 0", bad); else passed++;
    total++; if (dc !== lw + 1 || nd !== 1) $display("FAIL gaps_done got cyc %0d count %0d exp cyc %0d count 1", dc, nd, lw + 1); else passed++;
    total++; if (wlevel !== 5'd4) $display("FAIL gaps_wlevel got %0d exp 4", wlevel); else passed++;
  endtask

  task automatic test_wrap();
    int nwr, fw, lw, dc, nd, nr, bad;
    set_ptrs(5'd30, 5'd28);
    total++; if (wlevel !== 5'd2) $display("FAIL wrap_start got %0d exp 2", wlevel); else passed++;
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
    total++; if (walmost_full !== 1'b0) $display("FAIL af_low got %b exp 0", walmost_full); else passed++;
`endif
    stream(1'b1, 5'd3, 1'b0, 8'h70, 40, nwr, fw, lw, dc, nd, nr, bad);
    total++; if (nwr !== 3 || bad !== 0) $display("FAIL wrap_burst got %0d writes %0d bad exp 3/0", nwr, bad); else passed++;
    total++; if (wlevel !== 5'd5) $display("FAIL wrap_level got %0d exp 5", wlevel); else passed++;
    set_ptrs(5'd4, 5'd20);
    total++; if (wlevel !== 5'd16) $display("FAIL wrap_full_level got %0d exp 16", wlevel); else passed++;
`ifdef FIFO_BURST_WR_ALMOST_FULL_EN
    total++; if (walmost_full !== 1'b1) $display("FAIL af_high got %b exp 1", walmost_full); else passed++;
`endif
  endtask

  task automatic test_reset_mid_burst();
    int nwr, fw, lw, dc, nd, nr, bad, early;
    set_ptrs(5'd0, 5'd0);
    early = 0;
    cyc(1'b1, 5'd8, 1'b1, 8'h80);
    cyc(1'b0, 5'd8, 1'b1, 8'h80);
    cyc(1'b0, 5'd8, 1'b1, 8'h80);
    if (bif.winc) early++;
    cyc(1'b0, 5'd8, 1'b1, 8'h81);
    if (bif.winc) early++;
    total++; if (early !== 2) $display("FAIL mid_pre_writes got %0d exp 2", early); else passed++;
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    total++; if (bif.winc !== 1'b0 || busy !== 1'b0) $display("FAIL mid_reset got winc=%b busy=%b exp 0/0", bif.winc, busy); else passed++;
    total++; if (wlevel !== 5'd0 || burst_done !== 1'b0) $display("FAIL mid_reset_level got level=%0d done=%b exp 0/0", wlevel, burst_done); else passed++;
    @(negedge wclk);
    bif.s_valid = 1'b0;
    wrst_n = 1'b1;
    stream(1'b1, 5'd3, 1'b0, 8'h90, 40, nwr, fw, lw, dc, nd, nr, bad);
    total++; if (nr !== 1 || nwr !== 3 || bad !== 0) $display("FAIL mid_after got ready=%0d writes=%0d bad=%0d exp 1/3/0", nr, nwr, bad); else passed++;
    total++; if (nd !== 1 || wlevel !== 5'd5) $display("FAIL mid_after_done got done=%0d level=%0d exp 1/5", nd, wlevel); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_wait_space();
    test_zero_and_err();
    test_valid_gaps();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
- Write-domain initiator for the async FIFO's write-pointer/full generator: drives winc/wdata and consumes wfull, wptr and the synchronized read pointer wq2_rptr.
- Accepts burst requests (length N) and starts a burst only when the FIFO has at least N free entries, so a burst never stalls on wfull.
- Streams N data words from an upstream valid/ready source into the FIFO. Reports fill level and completion.

Parameters:
- ADDR_SIZE, 4, FIFO address width; DEPTH = 2^ADDR_SIZE.
- DATA_SIZE, 8, FIFO data width.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  burst request present.
- req_len  input  ADDR_SIZE+1  burst length in words, 0..DEPTH.
- req_ready  output  1  request accepted this cycle.
- s_valid  input  1  upstream data valid.
- s_data  input  DATA_SIZE  upstream data word.
- s_ready  output  1  upstream word consumed this cycle.
- winc  output  1  FIFO write strobe.
- wdata  output  DATA_SIZE  FIFO write data.
- wfull  input  1  FIFO full flag.
- wptr  input  ADDR_SIZE+1  FIFO write pointer, Gray.
- wq2_rptr  input  ADDR_SIZE+1  read pointer synchronized into wclk, Gray.
- wlevel  output  ADDR_SIZE+1  registered FIFO occupancy, 0..DEPTH.
- busy  output  1  state != IDLE.
- burst_done  output  1  one-cycle pulse after the final word of a burst is written, or for a zero-length request.
- req_err  output  1  one-cycle pulse when req_len > DEPTH.

Behaviour:
- Interface: reset wrst_n, asynchronous, active-low; clock wclk.
- Reset: state=IDLE, remaining count=0, wlevel=0, req_ready=0, burst_done=0, req_err=0. s_ready and winc are 0 because state is IDLE.
- Level:
  - wlevel <= gray2bin(wptr) - gray2bin(wq2_rptr), modulo 2^(ADDR_SIZE+1).
  - free = DEPTH - wlevel.
  - Both conversions are combinational XOR-prefix. Latency is 1 cycle after the pointer changes.
- FSM: IDLE, WAIT_SPACE, BURST, SETTLE.
  - IDLE, req_valid=1:
    - req_len > DEPTH: req_ready=1 and req_err=1 for one cycle; request is dropped; stay in IDLE.
    - req_len = 0: req_ready=1 and burst_done=1 for one cycle; no writes; stay in IDLE.
    - Otherwise: req_ready=1; latch len into remaining; go to WAIT_SPACE.
  - WAIT_SPACE: go to BURST when free >= remaining. Stay indefinitely otherwise.
  - BURST:
    - s_ready = winc = s_valid & ~wfull; wdata = s_data (combinational).
    - Each winc decrements remaining.
    - When winc=1 and remaining=1: go to SETTLE.
    - s_valid=0 idles the burst without error.
  - SETTLE: exactly one cycle so wlevel reflects the last write. burst_done=1 in this cycle. Go to IDLE.
- req_ready is 1 only in the accepting IDLE cycle. A new request can be accepted no earlier than the cycle after SETTLE.
- wfull in BURST should never assert given the space check. If it does, writes are held off (winc=0) and no word is lost.
- Pointer wrap-around: subtraction in ADDR_SIZE+1 bits gives the correct level across wrap. Level=DEPTH when the pointers differ only in the two MSBs (Gray).
- Reset mid-burst: immediate return to IDLE. The partial burst is abandoned with no burst_done.
- Reads on the far side during BURST only increase free; no action is required.

Optional Feature:
- Macro: FIFO_BURST_WR_ALMOST_FULL_EN.
- Defined:
  - Adds parameter AF_THRESH (default DEPTH-2) and output walmost_full (1 bit).
  - walmost_full <= (wlevel_next >= AF_THRESH), registered, reset 0.
- Undefined: neither the parameter nor the port exists; behaviour is otherwise identical.

Test Plan:
All scenarios use ADDR_SIZE=4, DEPTH=16.
- Reset, then empty FIFO with wptr=wq2_rptr=0; req_len=5 with s_valid held high -> req_ready 1 cycle; 5 consecutive winc cycles carrying data D0..D4; burst_done 1 cycle later; wlevel=5.
- wlevel=12, req_len=6 -> FSM holds in WAIT_SPACE with winc=0. Drive wq2_rptr forward by 2 (Gray) -> free=6, BURST starts; wlevel reaches 16 after the burst.
- req_len=0 -> req_ready and burst_done in the same cycle; no winc; state stays IDLE. req_len=17 -> req_err pulse; no winc.
- In BURST with remaining=4, toggle s_valid 1,0,1,0,... -> winc only on s_valid cycles; exactly 4 writes; burst_done after the 4th.
- Pointers near wrap, e.g. wptr=bin 30 and wq2_rptr=bin 28 -> wlevel=2. Write 3 words -> wptr wraps to 1 and wlevel=5.
- Assert wrst_n=0 mid-burst after 2 of 8 writes -> winc=0, busy=0, wlevel=0 immediately. After release, a new req_len=3 is accepted normally.
